// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared constants and FSM encoding for the data-memory responder.
package mips_mem_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;
    localparam int WORD_BYTES = 4;
    localparam int WORD_LSB   = 2;
    localparam int CNT_W      = 4;
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: 2^ADDR_BITS x 32 RAM, synchronous write port and a read port whose
// data the parent registers on the access edge.
module mem_word_array #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);
    logic [31:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed RAM behind valid/ready request and response channels with wait states.
// Define MISALIGN_CHK_EN to answer misaligned requests with an immediate error response and no RAM access.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 write_q, req_ready_q, rsp_valid_q, rsp_err_q;
    logic [ADDR_BITS-1:0] idx_q, req_idx, acc_idx;
    logic [31:0]          wdata_q, rsp_rdata_q, acc_wdata, ram_rdata, load_d;
    logic                 accept, misalign, access, acc_write, ram_we;
    logic                 unused_addr;

    assign req_idx     = req_addr[ADDR_BITS+WORD_LSB-1:WORD_LSB];
    assign accept      = req_valid && req_ready_q;
    assign unused_addr = ^{req_addr[31:ADDR_BITS+WORD_LSB], req_addr[WORD_LSB-1:0]};
`ifdef MISALIGN_CHK_EN
    assign misalign = req_addr[WORD_LSB-1:0] != '0;
`else
    assign misalign = 1'b0;
`endif

    // With zero wait states the access happens on the accept edge, so it uses the live request fields.
    assign acc_write = (state_q == S_IDLE) ? req_write : write_q;
    assign acc_idx   = (state_q == S_IDLE) ? req_idx : idx_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign access    = !rst && ((state_q == S_IDLE && accept && WAIT_CYCLES == 0 && !misalign) ||
                                (state_q == S_WAIT && cnt_q == '0));
    assign ram_we    = access && acc_write;
    assign load_d    = acc_write ? '0 : ram_rdata;

    mem_word_array #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (acc_idx),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        write_q     <= req_write;
                        idx_q       <= req_idx;
                        wdata_q     <= req_wdata;
                        cnt_q       <= CNT_INIT;
                        if (misalign) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (WAIT_CYCLES == 0) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= load_d;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench driving a 2-wait-state and a 0-wait-state responder.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        rv2 = 1'b0, rv0 = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        a_ready, a_rv, a_err, b_ready, b_rv, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        o_ready, o_rv, o_err;
    logic [31:0] o_rdata;

    data_mem_responder #(.ADDR_BITS(4), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(a_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rv), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    data_mem_responder #(.ADDR_BITS(4), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(b_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rv), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_rv    = sel ? b_rv : a_rv;
    assign o_err   = sel ? b_err : a_err;
    assign o_rdata = sel ? b_rdata : a_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m2 [16];
    logic [31:0] m0 [16];
    int          asserts = 0;
    int          fails = 0;

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input int bp);
        exp_t        e;
        exp_t        got;
        logic        mis;
        logic [31:0] held;
        int          n;
`ifdef MISALIGN_CHK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        if (sel) rv0 = 1'b1; else rv2 = 1'b1;
        n = 0;
        while (!o_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        asserts++;
        if (!o_ready) begin
            fails++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", o_ready);
            rv0 = 1'b0; rv2 = 1'b0;
            return;
        end
        e.err   = mis;
        e.lat   = (mis || sel) ? 4'd0 : 4'd2;
        e.rdata = (w || mis) ? 32'h0 : (sel ? m0[a[5:2]] : m2[a[5:2]]);
        if (w && !mis) begin
            if (sel) m0[a[5:2]] = d; else m2[a[5:2]] = d;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        rv0 = 1'b0; rv2 = 1'b0;
        asserts++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_drop @%h: req_ready=%0b required 0", a, o_ready);
        end
        n = 0;
        while (!o_rv && n < 20) begin
            @(posedge clk); #1; n++;
        end
        got = sb.pop_front();
        asserts++;
        if (!o_rv || n != int'(got.lat)) begin
            fails++;
            $display("FAIL latency @%h: rsp_valid=%0b after %0d edges, required 1 after %0d", a, o_rv, n, got.lat);
        end
        if (!o_rv) return;
        held = o_rdata;
        if (bp > 0) begin
            if (sel) rv0 = 1'b1; else rv2 = 1'b1;
            repeat (bp) begin
                @(posedge clk); #1;
                asserts++;
                if (o_rv !== 1'b1 || o_rdata !== held || o_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL backpressure_hold: valid=%0b rdata=%h ready=%0b required 1 %h 0", o_rv, o_rdata, o_ready, held);
                end
            end
            rv0 = 1'b0; rv2 = 1'b0;
        end
        asserts++;
        if (o_rdata !== got.rdata) begin
            fails++;
            $display("FAIL rsp_rdata @%h: got %h required %h", a, o_rdata, got.rdata);
        end
        asserts++;
        if (o_err !== got.err) begin
            fails++;
            $display("FAIL rsp_err @%h: got %0b required %0b", a, o_err, got.err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        asserts++;
        if (o_rv !== 1'b0 || o_rdata !== 32'h0 || o_err !== 1'b0 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL handshake_clear: valid=%0b rdata=%h err=%0b ready=%0b required 0 0 0 1", o_rv, o_rdata, o_err, o_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        asserts++;
        if ({a_ready, a_rv, a_err, b_ready, b_rv, b_err} !== 6'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: a=%0b%0b%0b %h b=%0b%0b%0b %h required all 0", a_ready, a_rv, a_err, a_rdata, b_ready, b_rv, b_err, b_rdata);
        end
        rst = 1'b0;
        asserts++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %0b%0b required 00", a_ready, b_ready);
        end
        @(posedge clk); #1;
        asserts++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %0b%0b required 11", a_ready, b_ready);
        end
    endtask

    task automatic test_store_load();
        sel = 1'b0;
        xact(1'b1, 32'h8, 32'hDEAD_BEEF, 0);
        xact(1'b0, 32'h8, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        xact(1'b1, 32'h10, 32'h1234_5678, 0);
        xact(1'b0, 32'h10, 32'h0, 5);
        xact(1'b1, 32'h14, 32'h0BAD_CAFE, 3);
    endtask

    task automatic test_alias();
        sel = 1'b0;
        xact(1'b1, 32'h04, 32'h11, 0);
        xact(1'b0, 32'h44, 32'h0, 0);
        xact(1'b0, 32'hFFFF_FF84, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xact(1'b1, 32'(i * 4 + 32), 32'hA000_0000 + 32'(i * 7), 0);
            xact(1'b0, 32'(i * 4 + 32), 32'h0, 0);
        end
    endtask

    task automatic test_reset_mid_store();
        sel = 1'b0;
        xact(1'b1, 32'h0, 32'hA5A5_A5A5, 0);
        req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h55; rv2 = 1'b1;
        @(posedge clk); #1;
        rv2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        asserts++;
        if (a_rv !== 1'b0 || a_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_wait: valid=%0b ready=%0b required 0 0", a_rv, a_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        xact(1'b0, 32'h0, 32'h0, 0);
    endtask

    task automatic test_zero_wait();
        sel = 1'b1;
        xact(1'b1, 32'hC, 32'hCAFE_F00D, 0);
        xact(1'b0, 32'hC, 32'h0, 0);
        xact(1'b0, 32'hC, 32'h0, 2);
`ifdef MISALIGN_CHK_EN
        xact(1'b0, 32'h6, 32'h0, 0);
        xact(1'b1, 32'hD, 32'h7777_7777, 0);
        xact(1'b0, 32'hC, 32'h0, 0);
        sel = 1'b0;
        xact(1'b0, 32'h9, 32'h0, 0);
`else
        xact(1'b0, 32'hE, 32'h0, 0);
`endif
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_alias();
        test_back_to_back();
        test_reset_mid_store();
        test_zero_wait();
        asserts++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end
endmodule
